id_ex_latch: RTL

ID/EX pipeline register of the MIPS core. It captures the outputs of the decode stage on each enabled clock edge and presents them to the execute stage one cycle later: the 32-bit sign-extender result, register operands, register addresses, PC+4 and the EX/MEM/WB control bundles. It inserts bubbles on hazard stall or branch flush, freezes completely when the debug unit deasserts run/step enable, and keeps a saturating bubble counter for the debug unit.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/sat_counter.sv | 19 +
 rtl/id_ex_latch.sv | 104 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline widths, control-bundle field positions and NOP encodings
package mips_pkg;

    localparam int NBITS          = 32;
    localparam int RNBITS         = 5;
    localparam int SHAMT_NBITS    = 5;
    localparam int EX_CTRL_NBITS  = 8;
    localparam int MEM_CTRL_NBITS = 6;
    localparam int WB_CTRL_NBITS  = 3;

    // EX bundle: [5:0] ALU op, [6] ALU src, [7] reg-dst select
    localparam int EX_ALU_OP_LSB  = 0;
    localparam int EX_ALU_OP_MSB  = 5;
    localparam int EX_ALU_SRC     = 6;
    localparam int EX_REG_DST     = 7;

    // MEM bundle: [0] read, [1] write, [3:2] access size, [4] unsigned load, [5] reserved
    localparam int MEM_READ       = 0;
    localparam int MEM_WRITE      = 1;
    localparam int MEM_SIZE_LSB   = 2;
    localparam int MEM_SIZE_MSB   = 3;
    localparam int MEM_UNSIGNED   = 4;

    localparam int WB_REG_WRITE   = 0;
    localparam int WB_MEM_TO_REG  = 1;
    localparam int WB_LINK        = 2;

    localparam logic [EX_CTRL_NBITS-1:0]  EX_CTRL_NOP  = '0;
    localparam logic [MEM_CTRL_NBITS-1:0] MEM_CTRL_NOP = '0;
    localparam logic [WB_CTRL_NBITS-1:0]  WB_CTRL_NOP  = '0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - parameterised saturating up-counter with enable
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {WIDTH{1'b1}})) begin
            o_count <= o_count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_latch.sv
// rtl/id_ex_latch.sv - ID/EX pipeline register with bubble insertion, debug freeze and bubble counter
module id_ex_latch
    import mips_pkg::*;
#(
    parameter int NBITS          = mips_pkg::NBITS,
    parameter int RNBITS         = mips_pkg::RNBITS,
    parameter int EX_CTRL_NBITS  = mips_pkg::EX_CTRL_NBITS,
    parameter int MEM_CTRL_NBITS = mips_pkg::MEM_CTRL_NBITS,
    parameter int WB_CTRL_NBITS  = mips_pkg::WB_CTRL_NBITS,
    parameter int CNT_NBITS      = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic [NBITS-1:0]          i_pc_plus4,
    input  logic [NBITS-1:0]          i_rs_data,
    input  logic [NBITS-1:0]          i_rt_data,
    input  logic [NBITS-1:0]          i_extensionresult,
    input  logic [RNBITS-1:0]         i_rs_addr,
    input  logic [RNBITS-1:0]         i_rt_addr,
    input  logic [RNBITS-1:0]         i_rd_addr,
    input  logic [4:0]                i_shamt,
    input  logic [EX_CTRL_NBITS-1:0]  i_ctrl_ex,
    input  logic [MEM_CTRL_NBITS-1:0] i_ctrl_mem,
    input  logic [WB_CTRL_NBITS-1:0]  i_ctrl_wb,
    output logic                      o_valid,
    output logic [NBITS-1:0]          o_pc_plus4,
    output logic [NBITS-1:0]          o_rs_data,
    output logic [NBITS-1:0]          o_rt_data,
    output logic [NBITS-1:0]          o_extensionresult,
    output logic [RNBITS-1:0]         o_rs_addr,
    output logic [RNBITS-1:0]         o_rt_addr,
    output logic [RNBITS-1:0]         o_rd_addr,
    output logic [4:0]                o_shamt,
    output logic [EX_CTRL_NBITS-1:0]  o_ctrl_ex,
    output logic [MEM_CTRL_NBITS-1:0] o_ctrl_mem,
    output logic [WB_CTRL_NBITS-1:0]  o_ctrl_wb,
    output logic [CNT_NBITS-1:0]      o_bubble_count
);

    logic bubble;

    // Stall and flush together still insert a single bubble.
    assign bubble = i_enable & (i_stall | i_flush);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid           <= 1'b0;
            o_pc_plus4        <= '0;
            o_rs_data         <= '0;
            o_rt_data         <= '0;
            o_extensionresult <= '0;
            o_rs_addr         <= '0;
            o_rt_addr         <= '0;
            o_rd_addr         <= '0;
            o_shamt           <= '0;
            o_ctrl_ex         <= '0;
            o_ctrl_mem        <= '0;
            o_ctrl_wb         <= '0;
        end else if (i_enable) begin
            if (bubble) begin
                o_valid           <= 1'b0;
                o_pc_plus4        <= '0;
                o_rs_data         <= '0;
                o_rt_data         <= '0;
                o_extensionresult <= '0;
                o_rs_addr         <= '0;
                o_rt_addr         <= '0;
                o_rd_addr         <= '0;
                o_shamt           <= '0;
                o_ctrl_ex         <= '0;
                o_ctrl_mem        <= '0;
                o_ctrl_wb         <= '0;
            end else begin
                o_valid           <= i_valid;
                o_pc_plus4        <= i_pc_plus4;
                o_rs_data         <= i_rs_data;
                o_rt_data         <= i_rt_data;
                o_extensionresult <= i_extensionresult;
                o_rs_addr         <= i_rs_addr;
                o_rt_addr         <= i_rt_addr;
                o_rd_addr         <= i_rd_addr;
                o_shamt           <= i_shamt;
                // An invalid decode slot carries data through but must not act.
                o_ctrl_ex         <= i_valid ? i_ctrl_ex  : '0;
                o_ctrl_mem        <= i_valid ? i_ctrl_mem : '0;
                o_ctrl_wb         <= i_valid ? i_ctrl_wb  : '0;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_NBITS)
    ) u_bubble_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (bubble),
        .o_count (o_bubble_count)
    );

endmodule
